// File: rtl/vga_pkg.sv
// Shared mode encodings and default 640x480@60 raster constants for the VGA timing path.
package vga_pkg;

   localparam logic [1:0] MODE_FULL = 2'd0;
   localparam logic [1:0] MODE_HALF = 2'd1;
   localparam logic [1:0] MODE_QTR  = 2'd2;

   localparam int DEF_H_DISP = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_DISP = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   function automatic int total(input int disp, input int fp, input int sync, input int bp);
      return disp + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_sig_delay.sv
// Fixed-length shift-register delay with synchronous clear; N = 0 is a plain wire.
module vga_sig_delay #(
   parameter int W = 3,
   parameter int N = 2
) (
   input  logic         CLK25,
   input  logic         reset,
   input  logic [W-1:0] sig,
   output logic [W-1:0] sig_dly
);

   generate
      if (N == 0) begin : g_pass
         logic unused_ok;
         assign unused_ok = CLK25 ^ reset;
         assign sig_dly   = sig;
      end else begin : g_shift
         // tap slice 0 is the input, slice gi+1 the output of stage gi
         logic [(N+1)*W-1:0] tap;
         assign tap[W-1:0] = sig;
         for (genvar gi = 0; gi < N; gi++) begin : g_stage
            logic [W-1:0] stage_reg;
            always_ff @(posedge CLK25) begin
               if (reset) stage_reg <= '0;
               else       stage_reg <= tap[gi*W +: W];
            end
            assign tap[(gi+1)*W +: W] = stage_reg;
         end
         assign sig_dly = tap[N*W +: W];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: sync/blank strobes delayed to match frame-buffer read
// latency, plus a per-frame scaled read window with a linear read address.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_DISP   = DEF_H_DISP,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_DISP   = DEF_V_DISP,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int SYNC_POL = 0,
   parameter int PIPE_DLY = 2,
   parameter int ADDR_W   = 19
) (
   input  logic              CLK25,
   input  logic              reset,
   input  logic [1:0]        mode,
   output logic              hsync,
   output logic              vsync,
   output logic              blank_n,
   output logic              sync_n,
   output logic              active_area,
   output logic [ADDR_W-1:0] pix_addr,
   output logic              frame_start,
   output logic [9:0]        h_pos,
   output logic [9:0]        v_pos
);

   localparam int H_TOTAL = total(H_DISP, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = total(V_DISP, V_FP, V_SYNC, V_BP);

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);
   localparam logic       SYNC_ACT = (SYNC_POL != 0);

   logic [9:0]        h_cnt_reg;
   logic [9:0]        v_cnt_reg;
   logic [1:0]        mode_q_reg;
   logic              hs0_reg;
   logic              vs0_reg;
   logic              bl0_reg;
   logic              active_reg;
   logic              frame_start_reg;
   logic [ADDR_W-1:0] pix_addr_reg;
   logic [9:0]        h_lim;
   logic [9:0]        v_lim;
   logic              frame_wrap;
   logic [2:0]        strobe_dly;

   assign frame_wrap = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

   always_comb begin
      h_lim = 10'(H_DISP);
      v_lim = 10'(V_DISP);
      case (mode_q_reg)
         MODE_HALF: begin
            h_lim = 10'(H_DISP >> 1);
            v_lim = 10'(V_DISP >> 1);
         end
         MODE_QTR: begin
            h_lim = 10'(H_DISP >> 2);
            v_lim = 10'(V_DISP >> 2);
         end
         default: ;
      endcase
   end

   // Window scale only changes at the frame boundary so a frame is never torn.
   always_ff @(posedge CLK25) begin
      if (reset) begin
         h_cnt_reg  <= '0;
         v_cnt_reg  <= '0;
         mode_q_reg <= MODE_FULL;
      end else begin
         if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
         end else begin
            h_cnt_reg <= h_cnt_reg + 10'd1;
         end
         if (frame_wrap) mode_q_reg <= (mode == 2'd3) ? MODE_FULL : mode;
      end
   end

   always_ff @(posedge CLK25) begin
      if (reset) begin
         hs0_reg         <= 1'b0;
         vs0_reg         <= 1'b0;
         bl0_reg         <= 1'b0;
         active_reg      <= 1'b0;
         frame_start_reg <= 1'b0;
         pix_addr_reg    <= '0;
      end else begin
         hs0_reg         <= (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
         vs0_reg         <= (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
         bl0_reg         <= (h_cnt_reg < 10'(H_DISP)) && (v_cnt_reg < 10'(V_DISP));
         active_reg      <= (h_cnt_reg < h_lim) && (v_cnt_reg < v_lim);
         frame_start_reg <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
         if (frame_wrap)      pix_addr_reg <= '0;
         else if (active_reg) pix_addr_reg <= pix_addr_reg + ADDR_W'(1);
      end
   end

   vga_sig_delay #(
      .W (3),
      .N (PIPE_DLY)
   ) u_sig_delay (
      .CLK25   (CLK25),
      .reset   (reset),
      .sig     ({hs0_reg, vs0_reg, bl0_reg}),
      .sig_dly (strobe_dly)
   );

   assign hsync       = strobe_dly[2] ~^ SYNC_ACT;
   assign vsync       = strobe_dly[1] ~^ SYNC_ACT;
   assign blank_n     = strobe_dly[0];
   assign sync_n      = 1'b1;
   assign active_area = active_reg;
   assign pix_addr    = pix_addr_reg;
   assign frame_start = frame_start_reg;
   assign h_pos       = h_cnt_reg;
   assign v_pos       = v_cnt_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: two reduced-raster instances (delay 0 / active-low, delay 3 / active-high) checked
// every cycle against a position-based model, plus a default 640x480 instance for hsync timing.
module tb_vga_timing_gen;

   localparam int HD = 40, HF = 4, HS = 8, HB = 8, HT = HD + HF + HS + HB;
   localparam int VD = 24, VF = 2, VS = 2, VB = 4, VT = VD + VF + VS + VB;
   localparam int FT = HT * VT;

   logic CLK25 = 1'b0;
   logic reset;
   logic [1:0] mode;

   logic hs0, vs0, bl0, sn0, act0, fs0;
   logic [18:0] pix0;
   logic [9:0] hp0, vp0;
   logic hs3, vs3, bl3, sn3, act3, fs3;
   logic [18:0] pix3;
   logic [9:0] hp3, vp3;
   logic hsd, vsd, bld, snd, actd, fsd;
   logic [18:0] pixd;
   logic [9:0] hpd, vpd;

   int checks = 0;
   int failures = 0;
   int c = 0;
   int frame_mode[64];
   int last_exp[4] = '{959, 59, 239, 959};

   always #20 CLK25 = ~CLK25;

   vga_timing_gen #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .SYNC_POL(0), .PIPE_DLY(0), .ADDR_W(19)) dut0 (
      .CLK25(CLK25), .reset(reset), .mode(mode), .hsync(hs0), .vsync(vs0), .blank_n(bl0),
      .sync_n(sn0), .active_area(act0), .pix_addr(pix0), .frame_start(fs0),
      .h_pos(hp0), .v_pos(vp0));

   vga_timing_gen #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .SYNC_POL(1), .PIPE_DLY(3), .ADDR_W(19)) dut3 (
      .CLK25(CLK25), .reset(reset), .mode(mode), .hsync(hs3), .vsync(vs3), .blank_n(bl3),
      .sync_n(sn3), .active_area(act3), .pix_addr(pix3), .frame_start(fs3),
      .h_pos(hp3), .v_pos(vp3));

   vga_timing_gen #(.PIPE_DLY(0)) dutd (
      .CLK25(CLK25), .reset(reset), .mode(mode), .hsync(hsd), .vsync(vsd), .blank_n(bld),
      .sync_n(snd), .active_area(actd), .pix_addr(pixd), .frame_start(fsd),
      .h_pos(hpd), .v_pos(vpd));

   // Raster position p (cycles since the counters restarted) -> stage-0 strobe values.
   function automatic bit hs_at(input int p);
      if (p < 0) return 1'b0;
      return (p % HT) >= HD + HF && (p % HT) < HD + HF + HS;
   endfunction

   function automatic bit vs_at(input int p);
      int v;
      if (p < 0) return 1'b0;
      v = (p / HT) % VT;
      return v >= VD + VF && v < VD + VF + VS;
   endfunction

   function automatic bit bl_at(input int p);
      if (p < 0) return 1'b0;
      return (p % HT) < HD && ((p / HT) % VT) < VD;
   endfunction

   function automatic int mode_eff(input int p);
      int m;
      m = frame_mode[p / FT];
      return (m == 3) ? 0 : m;
   endfunction

   function automatic bit act_at(input int p);
      int m;
      if (p < 0) return 1'b0;
      m = mode_eff(p);
      return (p % HT) < (HD >> m) && ((p / HT) % VT) < (VD >> m);
   endfunction

   // Window pixels already consumed in this frame by the time sample cyc is seen.
   function automatic int pix_at(input int cyc);
      int k, m, ww, wv, vv, hh, cnt;
      k = (cyc % FT) - 2;
      if (k < 0) return 0;
      m  = mode_eff(cyc);
      ww = HD >> m;
      wv = VD >> m;
      vv = k / HT;
      hh = k % HT;
      cnt = ((vv < wv) ? vv : wv) * ww;
      if (vv < wv) cnt += ((hh + 1) < ww) ? (hh + 1) : ww;
      return cnt;
   endfunction

   function automatic logic [1:0] sched(input int f);
      case (f)
         1: return 2'd2;
         2: return 2'd1;
         3: return 2'd3;
         default: return 2'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
      end
   endtask

   task automatic check_dut(input string tag, input int dly, input bit pol,
                            input logic hs, input logic vs, input logic bl, input logic sn,
                            input logic act, input logic fs, input logic [18:0] pix,
                            input logic [9:0] hp, input logic [9:0] vp);
      int p;
      p = c - 1 - dly;
      chk({tag, ".hsync"}, int'(hs), int'(hs_at(p) == pol));
      chk({tag, ".vsync"}, int'(vs), int'(vs_at(p) == pol));
      chk({tag, ".blank_n"}, int'(bl), int'(bl_at(p)));
      chk({tag, ".sync_n"}, int'(sn), 1);
      chk({tag, ".active_area"}, int'(act), int'(act_at(c - 1)));
      chk({tag, ".frame_start"}, int'(fs), int'(c >= 1 && ((c - 1) % FT) == 0));
      chk({tag, ".pix_addr"}, int'(pix), pix_at(c));
      chk({tag, ".h_pos"}, int'(hp), c % HT);
      chk({tag, ".v_pos"}, int'(vp), (c / HT) % VT);
   endtask

   initial begin
      logic rst_d;
      logic [1:0] mode_d;
      int seg, bl_cnt, hs_cnt, vs_cnt, fs_cnt, last_pix, fall_c, rise_c;
      bit done, just_reset, prev_hsd;
      seg = 0; bl_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; last_pix = -1;
      fall_c = -1; rise_c = -1; done = 0; just_reset = 0; prev_hsd = 1'b1;
      reset = 1'b1;
      mode  = 2'd0;
      for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
         rst_d  = reset;
         mode_d = mode;
         @(posedge CLK25);
         #1;
         if (rst_d) c = 0;
         else       c++;
         if (c == 0) frame_mode[0] = 0;
         else if (c % FT == 0) begin
            frame_mode[c / FT] = int'(mode_d);
            $display("frame %0d seg %0d done, next mode %0d", c / FT - 1, seg, mode_d);
         end

         check_dut("d0", 0, 1'b0, hs0, vs0, bl0, sn0, act0, fs0, pix0, hp0, vp0);
         check_dut("d3", 3, 1'b1, hs3, vs3, bl3, sn3, act3, fs3, pix3, hp3, vp3);

         if (cyc == 1) begin
            chk("rst.hsync_lo", int'(hs0), 1);
            chk("rst.hsync_hi", int'(hs3), 0);
            chk("rst.vsync", int'(vs0), 1);
            chk("rst.blank_n", int'(bl0), 0);
            chk("rst.active", int'(act0), 0);
            chk("rst.pix_addr", int'(pix0), 0);
            chk("rst.frame_start", int'(fs0), 0);
            chk("rst.def_hsync", int'(hsd), 1);
         end

         if (just_reset) begin
            chk("midrst.vsync", int'(vs0), 1);
            chk("midrst.hsync", int'(hs0), 1);
            chk("midrst.vsync_hi", int'(vs3), 0);
            chk("midrst.blank_n", int'(bl3), 0);
            chk("midrst.pix_addr", int'(pix0), 0);
            chk("midrst.h_pos", int'(hp0), 0);
            just_reset = 0;
         end

         if (seg == 0 && c >= 1 && c <= FT) begin
            bl_cnt += int'(bl0);
            hs_cnt += int'(!hs0);
            vs_cnt += int'(!vs0);
            fs_cnt += int'(fs0);
            if (c == FT) begin
               chk("frame0.blank_cycles", bl_cnt, HD * VD);
               chk("frame0.hsync_low", hs_cnt, HS * VT);
               chk("frame0.vsync_low", vs_cnt, VS * HT);
               chk("frame0.frame_starts", fs_cnt, 1);
            end
         end

         if (seg == 0 && act0) last_pix = int'(pix0);
         if (seg == 0 && c > 0 && c % FT == 0 && c / FT <= 4)
            chk("frame.last_pix", last_pix, last_exp[c / FT - 1]);

         if (seg == 0 && c >= 1 && c <= 1000) begin
            if (prev_hsd && !hsd && fall_c < 0) fall_c = c;
            if (!prev_hsd && hsd && fall_c >= 0 && rise_c < 0) rise_c = c;
            prev_hsd = hsd;
            if (c == 1000) begin
               chk("def.hsync_fall", fall_c, 657);
               chk("def.hsync_width", rise_c - fall_c, 96);
            end
         end

         if (cyc < 2) reset = 1'b1;
         else if (seg == 0 && c / FT == 8 && c % FT == (VD + VF) * HT + 50 && !rst_d) begin
            reset = 1'b1;
            seg = 1;
            just_reset = 1;
         end else reset = 1'b0;

         mode = (c % FT == FT - 1) ? sched(c / FT + 1) : 2'($urandom_range(0, 3));

         if (seg == 1 && !rst_d && c == 3 * FT) done = 1;
      end
      chk("run_complete", int'(done), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
